// File: rtl/unary_pkg.sv
// ---------------------------------------------------------------------------
// unary_pkg
// Definitions shared by the unary bit-stream generator and the unary-to-binary
// decoder, so that both ends agree on frame length and FSM state names.
//   state_t   : FSM states (IDLE, COUNT, DONE)
//   frame_len : frame length in cycles for a given binary width, 2^width - 1
// ---------------------------------------------------------------------------
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned frame_len(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/unary_frame_counter.sv
// ---------------------------------------------------------------------------
// unary_frame_counter
// Bit-position counter for one unary frame. Loading puts the counter on
// position 1 (position 0 is consumed on the load cycle itself); each advance
// steps it, and the advance that consumes the last position (L-1) returns it
// to 0. The counter therefore reads non-zero exactly while a frame is in
// progress after its first bit.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   i_load    in   frame accepted this cycle (bit 0 being sampled)
//   i_advance in   one more frame bit sampled this cycle
//   o_pos     out  WIDTH-bit position of the bit sampled on the next edge
//   o_last    out  o_pos is the final position of the frame (L-1)
// ---------------------------------------------------------------------------
module unary_frame_counter
  import unary_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_pos,
  output logic             o_last
);

  localparam logic [WIDTH-1:0] LAST_POS = WIDTH'(frame_len(WIDTH) - 32'd1);

  logic [WIDTH-1:0] r_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos <= '0;
    end else if (i_load) begin
      r_pos <= WIDTH'(1);
    end else if (i_advance) begin
      r_pos <= (r_pos == LAST_POS) ? '0 : r_pos + WIDTH'(1);
    end
  end

  assign o_pos  = r_pos;
  assign o_last = (r_pos == LAST_POS);

endmodule

// File: rtl/unary_to_binary.sv
// ---------------------------------------------------------------------------
// unary_to_binary
// Receives a serial unary frame of L = 2^WIDTH - 1 bits, counts its ones and
// presents the count with a one-cycle valid pulse. Also reports whether the
// frame was not a clean thermometer code (a 1 seen after a 0).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   start    in   frame start; the accepting cycle carries frame bit 0
//   un_data  in   serial unary bit
//   bin_out  out  ones count of the last completed frame (held)
//   valid    out  one-cycle pulse when bin_out/err have just been updated
//   busy     out  frame being sampled; start is ignored
//   err      out  last completed frame was not a thermometer code (held)
// ---------------------------------------------------------------------------
module unary_to_binary
  import unary_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             un_data,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_seen0;
  logic             r_bad;
  logic [WIDTH-1:0] r_bin_out;
  logic             r_err;

  logic             w_accept;
  logic             w_counting;
  logic [WIDTH-1:0] w_pos;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_sum;
  logic             w_bad_sum;

  // A new frame may start from IDLE or directly from DONE (back-to-back).
  assign w_accept   = start && (r_state != COUNT);
  assign w_counting = (r_state == COUNT);

  // Running totals including the bit being sampled this cycle.
  assign w_acc_sum = r_acc + WIDTH'(un_data);
  assign w_bad_sum = r_bad | (un_data & r_seen0);

  unary_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_advance (w_counting),
    .o_pos     (w_pos),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_seen0   <= 1'b0;
      r_bad     <= 1'b0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= COUNT;
            r_acc   <= WIDTH'(un_data);
            r_seen0 <= ~un_data;
            r_bad   <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        COUNT: begin
          r_acc <= w_acc_sum;
          r_bad <= w_bad_sum;
          if (!un_data) begin
            r_seen0 <= 1'b1;
          end
          if (w_last) begin
            r_bin_out <= w_acc_sum;
            r_err     <= w_bad_sum;
            r_state   <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bin_out = r_bin_out;
  assign err     = r_err;
  assign valid   = (r_state == DONE);
  // The position counter is non-zero exactly during the COUNT cycles.
  assign busy    = |w_pos;

endmodule

// File: tb/tb_unary_to_binary.sv
module tb_unary_to_binary;

  localparam int WIDTH = 5;
  localparam int L     = 31;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             un_data;
  logic [WIDTH-1:0] bin_out;
  logic             valid;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  unary_to_binary #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .un_data (un_data),
    .bin_out (bin_out),
    .valid   (valid),
    .busy    (busy),
    .err     (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int count;
    int shape_err;
    int due_cyc;
  } exp_t;

  exp_t q[$];

  // Last published result, against which held outputs are checked.
  int hold_bin = 0;
  int hold_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: pops expectations whenever the decoder publishes a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (valid === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          e = q.pop_front();
          $display("frame: bin_out=%0d err=%0d cyc=%0d (expected %0d/%0d @%0d)",
                   bin_out, err, cyc, e.count, e.shape_err, e.due_cyc);
          check("bin_out", 32'(bin_out), e.count);
          check("err", 32'(err), e.shape_err);
          check("valid_cycle", cyc, e.due_cyc);
          hold_bin = e.count;
          hold_err = e.shape_err;
        end
      end else begin
        check("hold_bin_out", 32'(bin_out), hold_bin);
        check("hold_err", 32'(err), hold_err);
      end
    end
  end

  function automatic logic [L-1:0] thermo(input int n);
    logic [L-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start   = 1'b0;
      un_data = 1'($urandom_range(0, 1));
    end
  endtask

  // Drives one frame (bit 0 first). glitch: extra start pulses mid-frame,
  // always including one at bit 10. abort_at >= 0: reset at that bit.
  task automatic run_frame(input logic [L-1:0] bits, input bit glitch, input int abort_at);
    int ones;
    bit zero_seen;
    bit shape_bad;
    exp_t e;
    ones = 0;
    zero_seen = 1'b0;
    shape_bad = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (bits[i]) begin
        ones++;
        if (zero_seen) shape_bad = 1'b1;
      end else begin
        zero_seen = 1'b1;
      end
    end
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        #1 rst = 1'b1;
        hold_bin = 0;
        hold_err = 0;
        #1;
        check("abort_bin_out", 32'(bin_out), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        return;
      end
      if (i == 0) begin
        check("busy_at_accept", 32'(busy), 32'd0);
        start = 1'b1;
        if (abort_at < 0) begin
          e.count     = ones;
          e.shape_err = int'(shape_bad);
          e.due_cyc   = cyc + L;
          q.push_back(e);
        end
      end else begin
        start = glitch ? ((i == 10) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        if (i == 1 || i == L - 1) check("busy_in_frame", 32'(busy), 32'd1);
      end
      un_data = bits[i];
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [L-1:0] bits;
    int gen_vals[4];
    gen_vals = '{0, 1, 30, 31};

    rst     = 1'b1;
    start   = 1'b0;
    un_data = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bin_out", 32'(bin_out), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    idle(2);

    // 13 ones then 18 zeros
    run_frame(thermo(13), 1'b0, -1);
    idle(3);

    // all zeros then all ones, back-to-back
    run_frame(thermo(0), 1'b0, -1);
    run_frame(thermo(L), 1'b0, -1);
    idle(2);

    // malformed 1,0,1 then a clean frame of 5 ones
    bits = '0;
    bits[0] = 1'b1;
    bits[2] = 1'b1;
    run_frame(bits, 1'b0, -1);
    run_frame(thermo(5), 1'b0, -1);
    idle(2);

    // start pulses during a frame are ignored
    run_frame(thermo(20), 1'b1, -1);
    idle(2);

    // reset mid-frame, then a fresh frame of 7 ones
    run_frame(thermo(9), 1'b0, 15);
    idle(2);
    run_frame(thermo(7), 1'b0, -1);
    idle(2);

    // frames as a unary generator emits them for 0, 1, 30, 31
    foreach (gen_vals[k]) run_frame(thermo(gen_vals[k]), 1'b0, -1);
    idle(2);

    // random thermometer and arbitrary frames
    repeat (24) begin
      rnd = $urandom;
      if ($urandom_range(0, 1) == 1) bits = thermo(int'($urandom_range(0, L)));
      else bits = rnd[L-1:0];
      run_frame(bits, 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);

    for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
    check("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unary_to_binary.md
# unary_to_binary

Unary-to-binary decoder: the receiving end of the unary bit-stream generator. Samples one serial unary bit per clock over a fixed frame of 2^WIDTH−1 cycles, counts the ones, and presents the recovered binary value with a one-cycle valid pulse. It also flags frames that are not well-formed thermometer codes. It sits downstream of a unary stream source, or at the output of a unary/stochastic compute stage, and returns results to binary logic.

## Interface
- WIDTH, 5, binary precision m; frame length L = 2^WIDTH − 1 cycles (31 at default)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  frame start; cycle where start is accepted carries frame bit 0 on un_data
- un_data  input  1  serial unary bit, sampled every rising edge while a frame is in progress
- bin_out  output  WIDTH  decoded ones count of last completed frame; held until next completion
- valid  output  1  one-cycle pulse; bin_out/err updated this cycle
- busy  output  1  high while a frame is being sampled (start ignored)
- err  output  1  last completed frame contained a 1 after a 0 (not thermometer); qualified by valid, held with bin_out

## Operation
- States: IDLE, COUNT, DONE.
- IDLE: busy=0, valid=0. start=1 → sample un_data as bit 0, pos←1, acc←un_data, seen0←~un_data, bad←0, go COUNT.
- COUNT: busy=1. Each edge: acc←acc+un_data; if un_data=1 and seen0=1 then bad←1; if un_data=0 then seen0←1; pos←pos+1. Edge sampling bit L−1 (pos=L−1): bin_out←final acc, err←final bad, go DONE.
- DONE: valid=1, busy=0 for exactly one cycle. If start=1 in DONE, a new frame begins exactly as from IDLE (back-to-back frames, no gap); otherwise go IDLE.
- start while busy=1 is ignored; it neither restarts nor extends the frame.
- Arithmetic: acc and pos are WIDTH bits; acc max is L = 2^WIDTH−1, so no overflow or saturation is needed. pos never wraps inside a frame.
- Ones need not be contiguous: bin_out is always the popcount of the frame. err only reports shape.
- All-zero frame → bin_out=0, err=0. All-one frame → bin_out=L, err=0.

## Timing
- Reset (async assert, sync release on clk): state=IDLE, bin_out=0, valid=0, busy=0, err=0, internal counters 0.
- Reset mid-frame aborts the frame immediately; no valid is produced for it. bin_out returns to 0.
- Frame accepted at cycle t (start=1, state IDLE or DONE): bits sampled at edges ending cycles t … t+L−1. busy is high in cycles t+1 … t+L−1. valid is high in cycle t+L.
- Latency from last data bit to valid: 1 cycle. Throughput: one result per L cycles with back-to-back start.
- bin_out and err change only on the edge that enters DONE; they are stable otherwise.

## Structure
- Shared package unary_pkg: state enum (IDLE, COUNT, DONE); function frame_len(width) = 2^width − 1. The generator and the decoder use the same frame-length definition.
- One natural sub-module: unary_frame_counter (pos counter plus terminal-count flag at L−1), reusable by the generator side for frame framing.
- acc, seen0, bad and the FSM stay in the top module.

## Test plan
- WIDTH=5. start at t0, un_data = 13 ones then 18 zeros → valid at t0+31, bin_out=13, err=0. busy is high t0+1…t0+30.
- All zeros, then all ones, back-to-back with start held high in DONE → two valid pulses 31 cycles apart, bin_out=0 then 31, err=0 both.
- Pattern 1,0,1 then 28 zeros → bin_out=2, err=1. The next clean frame of 5 ones → bin_out=5, err=0.
- start pulsed again at t0+10 during a frame → ignored; single valid at t0+31 with the correct count.
- rst asserted at t0+15 mid-frame → outputs 0 asynchronously, no valid. A new start after release decodes 7 ones → bin_out=7.
- Drive the decoder from the unary generator loaded with 0, 1, 30 and 31 (aligned frames) → bin_out equals each loaded value, err=0.
